// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the bit-serial comparator.
// The signed/unsigned choice (SERIAL_CMP_SIGNED_EN) lives in serial_cmp_decide.

package serial_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter just large enough to index bits 0..width-1, never narrower than one bit
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// Handshake and result bundle between a bit-serial source and serial_comparator.
// The master side feeds bit pairs; the slave side is the comparator itself.

interface serial_comparator_if;

    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic eq;
    logic gt;
    logic lt;
    logic ge;
    logic le;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, eq, gt, lt, ge, le
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, eq, gt, lt, ge, le
    );

endinterface

// File: rtl/serial_cmp_decide.sv
// First-difference decision flags for an MSB-first serial compare.
// With SERIAL_CMP_SIGNED_EN defined, a difference in the sign bit inverts the verdict.

module serial_cmp_decide (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample,
    input  logic is_msb,
    input  logic a_bit,
    input  logic b_bit,
    output logic decided,
    output logic gt
);

`ifdef SERIAL_CMP_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic differ;
    logic gt_now;

    assign differ = a_bit ^ b_bit;

    // In two's complement a set sign bit means the smaller value, so B's bit wins there
    assign gt_now = (is_msb && SIGNED_EN) ? b_bit : a_bit;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            decided <= 1'b0;
            gt      <= 1'b0;
        end else if (sample && !decided && differ) begin
            decided <= 1'b1;
            gt      <= gt_now;
        end
    end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: WIDTH bit pairs MSB first, then a DONE pulse with flags.
// Signed (two's complement) compare is selected by defining SERIAL_CMP_SIGNED_EN.

module serial_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_comparator_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept_start;
    logic             sample;
    logic             last_bit;
    logic             in_done;
    logic             decided;
    logic             dec_gt;

    logic eq_live, gt_live, lt_live;
    logic eq_q, gt_q, lt_q;

    assign last_bit = (cnt == LAST_IDX);
    assign in_done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        sample       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept_start = 1'b1;
                    state_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.bit_valid) begin
                    sample = 1'b1;
                    if (last_bit) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    accept_start = 1'b1;
                    state_next   = S_SHIFT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counter stops at the last index; the FSM leaves SHIFT on that same sample
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            cnt <= '0;
        end else if (sample && !last_bit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    serial_cmp_decide u_decide (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept_start),
        .sample  (sample),
        .is_msb  (cnt == '0),
        .a_bit   (bus.a_bit),
        .b_bit   (bus.b_bit),
        .decided (decided),
        .gt      (dec_gt)
    );

    assign eq_live = !decided;
    assign gt_live = decided && dec_gt;
    assign lt_live = decided && !dec_gt;

    // Decision flags may be cleared by a back-to-back START, so the verdict is held here
    always_ff @(posedge clk) begin
        if (rst) begin
            eq_q <= 1'b0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else if (in_done) begin
            eq_q <= eq_live;
            gt_q <= gt_live;
            lt_q <= lt_live;
        end
    end

    assign bus.busy = (state == S_SHIFT);
    assign bus.done = in_done;
    assign bus.eq   = in_done ? eq_live : eq_q;
    assign bus.gt   = in_done ? gt_live : gt_q;
    assign bus.lt   = in_done ? lt_live : lt_q;
    assign bus.ge   = bus.eq | bus.gt;
    assign bus.le   = bus.eq | bus.lt;

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator: vector table, corner sequences, random compares.
// Expected flags follow SERIAL_CMP_SIGNED_EN the same way as the design build.

module tb_serial_comparator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_comparator_if bus();

    serial_comparator #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] exp_u;
        logic [4:0] exp_s;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Flag order used everywhere: {eq, gt, lt, ge, le}
    function automatic logic [4:0] flags();
        return {bus.eq, bus.gt, bus.lt, bus.ge, bus.le};
    endfunction

    function automatic logic [4:0] ref_flags(input logic [7:0] a, input logic [7:0] b);
        logic e, g, l;
        e = (a == b);
`ifdef SERIAL_CMP_SIGNED_EN
        g = ($signed(a) > $signed(b));
        l = ($signed(a) < $signed(b));
`else
        g = (a > b);
        l = (a < b);
`endif
        return {e, g, l, e | g, e | l};
    endfunction

    task automatic feedBits(input logic [7:0] a, input logic [7:0] b, input int max_gap,
                            input bit noise, output int cycles, output bit shift_ok);
        int gap;
        cycles   = 0;
        shift_ok = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                bus.bit_valid = 1'b0;
                bus.a_bit     = 1'($urandom);
                bus.b_bit     = 1'($urandom);
                bus.start     = noise ? 1'($urandom) : 1'b0;
                if (!bus.busy || bus.done) shift_ok = 1'b0;
                tick();
                cycles++;
            end
            bus.bit_valid = 1'b1;
            bus.a_bit     = a[i];
            bus.b_bit     = b[i];
            bus.start     = noise ? 1'($urandom) : 1'b0;
            if (!bus.busy || bus.done) shift_ok = 1'b0;
            tick();
            cycles++;
        end
        bus.bit_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    // START cycle carries junk bits that must be ignored
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int max_gap,
                                 input bit noise, output logic [4:0] result,
                                 output logic done_seen, output int cycles, output bit shift_ok);
        bus.start     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.a_bit     = 1'($urandom);
        bus.b_bit     = 1'($urandom);
        tick();
        bus.start = 1'b0;
        feedBits(a, b, max_gap, noise, cycles, shift_ok);
        result    = flags();
        done_seen = bus.done;
    endtask

    initial begin
        logic [4:0] res;
        logic [4:0] exp;
        logic       dn;
        int         cyc;
        bit         sok;
        logic [7:0] ra, rb;

        vecs[0] = '{8'h05, 8'h03, 5'b01010, 5'b01010};
        vecs[1] = '{8'h80, 8'h7F, 5'b01010, 5'b00101};
        vecs[2] = '{8'hFF, 8'hFF, 5'b10011, 5'b10011};
        vecs[3] = '{8'h01, 8'h02, 5'b00101, 5'b00101};
        vecs[4] = '{8'h7F, 8'h00, 5'b01010, 5'b01010};
        vecs[5] = '{8'h00, 8'hFF, 5'b00101, 5'b01010};
        vecs[6] = '{8'h10, 8'h20, 5'b00101, 5'b00101};
        vecs[7] = '{8'hFE, 8'hFF, 5'b00101, 5'b00101};
        vecs[8] = '{8'h81, 8'h80, 5'b01010, 5'b01010};
        vecs[9] = '{8'h00, 8'h00, 5'b10011, 5'b10011};

        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a_bit     = 1'b0;
        bus.b_bit     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset flags", 32'(flags()), 32'd0);

        bus.bit_valid = 1'b1;
        bus.a_bit     = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        checkOutput("idle bit_valid ignored", 32'({bus.busy, bus.done}), 32'd0);

        for (int i = 0; i < 10; i++) begin
`ifdef SERIAL_CMP_SIGNED_EN
            exp = vecs[i].exp_s;
`else
            exp = vecs[i].exp_u;
`endif
            applyStimulus(vecs[i].a, vecs[i].b, 0, 1'b0, res, dn, cyc, sok);
            checkOutput("vec flags", 32'(res), 32'(exp));
            checkOutput("vec done", 32'(dn), 32'd1);
            checkOutput("vec latency", 32'(cyc), 32'(W));
            checkOutput("vec busy in shift", 32'(sok), 32'd1);
            tick();
            checkOutput("vec done pulse", 32'({bus.busy, bus.done}), 32'd0);
            checkOutput("vec flags hold", 32'(flags()), 32'(exp));
        end

        applyStimulus(8'hFF, 8'hFF, 3, 1'b1, res, dn, cyc, sok);
        checkOutput("gap eq flags", 32'(res), 32'b10011);
        checkOutput("gap eq done", 32'(dn), 32'd1);
        checkOutput("gap busy in shift", 32'(sok), 32'd1);
        tick();
        checkOutput("gap done pulse", 32'({bus.busy, bus.done}), 32'd0);

        applyStimulus(8'h01, 8'h02, 0, 1'b0, res, dn, cyc, sok);
        checkOutput("b2b first flags", 32'(res), 32'b00101);
        checkOutput("b2b first done", 32'(dn), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("b2b restart busy", 32'({bus.busy, bus.done}), 32'b10);
        checkOutput("b2b flags hold", 32'(flags()), 32'b00101);
        feedBits(8'h7F, 8'h00, 0, 1'b0, cyc, sok);
        checkOutput("b2b second flags", 32'(flags()), 32'b01010);
        checkOutput("b2b second done", 32'(bus.done), 32'd1);
        checkOutput("b2b period", 32'(cyc + 1), 32'(W + 1));
        tick();

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = W - 1; i >= W - 4; i--) begin
            bus.bit_valid = 1'b1;
            bus.a_bit     = 1'(8'h10 >> i);
            bus.b_bit     = 1'(8'h20 >> i);
            tick();
        end
        bus.bit_valid = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        checkOutput("abort state", 32'({bus.busy, bus.done}), 32'd0);
        checkOutput("abort flags", 32'(flags()), 32'd0);
        tick();
        checkOutput("rst beats start", 32'(bus.busy), 32'd0);
        applyStimulus(8'h20, 8'h10, 0, 1'b0, res, dn, cyc, sok);
        checkOutput("post abort flags", 32'(res), 32'b01010);
        checkOutput("post abort done", 32'(dn), 32'd1);
        tick();

        for (int n = 0; n < 1500; n++) begin
            ra = 8'($urandom);
            case ($urandom_range(3, 0))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(7, 0));
                default: rb = 8'($urandom);
            endcase
            applyStimulus(ra, rb, ($urandom_range(3, 0) == 0) ? 2 : 0, 1'($urandom),
                          res, dn, cyc, sok);
            exp = ref_flags(ra, rb);
            checkOutput("rand flags", 32'({ra, rb, 11'd0, res}), 32'({ra, rb, 11'd0, exp}));
            checkOutput("rand done", 32'(dn), 32'd1);
            checkOutput("rand busy in shift", 32'(sok), 32'd1);
            tick();
            checkOutput("rand hold", 32'({bus.done, flags()}), 32'({1'b0, exp}));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
